// File: rtl/tpu_core_param_pkg.sv
// rtl/tpu_core_param_pkg.sv - opcode and FSM state types shared by the mini-TPU core
package tpu_core_param_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'b000,
        OP_LOAD_A  = 3'b001,
        OP_LOAD_B  = 3'b010,
        OP_COMPUTE = 3'b011,
        OP_READ    = 3'b100,
        OP_CLEAR   = 3'b101,
        OP_RSVD0   = 3'b110,
        OP_RSVD1   = 3'b111
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Cycles needed for the last skewed operand pair to reach PE(N-1,N-1).
    function automatic int run_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/tpu_core_param_pe.sv
// rtl/tpu_core_param_pe.sv - systolic MAC processing element with a/b pass registers
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear of the a/b pass registers
//   en              advance pipeline and accumulate this cycle
//   acc_clr         synchronous clear of the accumulator
//   a_in, b_in      operands from the west / north neighbour
//   a_out, b_out    registered operands towards east / south
//   acc             accumulated result (wraps modulo 2^ACC_W)
module tpu_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              acc_clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
            a_d = '0;
            b_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + ACC_W'(prod);
        end
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/tpu_core_param.sv
// rtl/tpu_core_param.sv - parametrised NxN output-stationary systolic mini-TPU core
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid/instr_ready     instruction handshake (transfer on valid && ready)
//   instruction                 {op, pad, row, col, data}
//   result, result_valid        READ data and its one-cycle strobe
//   busy                        high while COMPUTE runs
//   done                        pulse on the last COMPUTE cycle
module tpu_core_param
    import tpu_core_param_pkg::*;
#(
    parameter int N       = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ACC_W-1:0]   result,
    output logic               result_valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W    = $clog2(N);
    localparam int RUN_LEN  = run_cycles(N);
    localparam int CNT_W    = $clog2(RUN_LEN);
    localparam int PAD_W    = INSTR_W - OP_W - 2 * IDX_W - DATA_W;

    opcode_e           op;
    logic [IDX_W-1:0]  row, col;
    logic [DATA_W-1:0] data;

    assign op   = opcode_e'(instruction[INSTR_W-1 -: OP_W]);
    assign data = instruction[DATA_W-1:0];
    assign col  = instruction[DATA_W +: IDX_W];
    assign row  = instruction[DATA_W + IDX_W +: IDX_W];

    generate
        if (PAD_W > 0) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^instruction[INSTR_W-OP_W-1 -: PAD_W];
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_buf_q [N][N];
    logic [DATA_W-1:0] a_buf_d [N][N];
    logic [DATA_W-1:0] b_buf_q [N][N];
    logic [DATA_W-1:0] b_buf_d [N][N];
    logic [ACC_W-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              pe_clr, acc_clr, run;

    logic [DATA_W-1:0] a_link [N][N+1];
    logic [DATA_W-1:0] b_link [N+1][N];
    logic [ACC_W-1:0]  c_acc  [N][N];

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        a_buf_d        = a_buf_q;
        b_buf_d        = b_buf_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        pe_clr         = 1'b0;
        acc_clr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (op)
                        OP_LOAD_A:  a_buf_d[row][col] = data;
                        OP_LOAD_B:  b_buf_d[row][col] = data;
                        OP_COMPUTE: begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                            pe_clr  = 1'b1;
                        end
                        OP_READ: begin
                            result_d       = c_acc[row][col];
                            result_valid_d = 1'b1;
                        end
                        OP_CLEAR:   acc_clr = 1'b1;
                        default:    ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(RUN_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            a_buf_q        <= '{default: '0};
            b_buf_q        <= '{default: '0};
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_buf_q        <= a_buf_d;
            b_buf_q        <= b_buf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j].
    // The offset is one bit wider than cnt so that t < i wraps to a large
    // value and falls outside the 0..N-1 window.
    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : g_skew
            logic [CNT_W:0] off;
            assign off = {1'b0, cnt_q} - (CNT_W+1)'(i);
            assign a_link[i][0] = (off < (CNT_W+1)'(N)) ? a_buf_q[i][off[IDX_W-1:0]] : '0;
            assign b_link[0][i] = (off < (CNT_W+1)'(N)) ? b_buf_q[off[IDX_W-1:0]][i] : '0;
        end

        for (i = 0; i < N; i++) begin : g_row
            for (j = 0; j < N; j++) begin : g_col
                tpu_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W)
                ) u_pe (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .clr     (pe_clr),
                    .en      (run),
                    .acc_clr (acc_clr),
                    .a_in    (a_link[i][j]),
                    .b_in    (b_link[i][j]),
                    .a_out   (a_link[i][j+1]),
                    .b_out   (b_link[i+1][j]),
                    .acc     (c_acc[i][j])
                );
            end
        end
    endgenerate

    assign instr_ready  = (state_q == ST_IDLE);
    assign busy         = run;
    assign done         = run && (cnt_q == CNT_W'(RUN_LEN - 1));
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_tpu_core_param.sv
// tb/tb_tpu_core_param.sv - self-checking bench for tpu_core_param with a matrix reference model
module tb_tpu_core_param;

    localparam int N       = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int INSTR_W = 16;

    localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, LDB = 3'b010,
                           CMP = 3'b011, RD  = 3'b100, CLR = 3'b101;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic [ACC_W-1:0]   result;
    logic               result_valid;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;
    int ma[N][N];
    int mb[N][N];
    int mc[N][N];

    tpu_core_param #(
        .N       (N),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input int r, input int c, input int d);
        logic [1:0] rr, cc;
        logic [7:0] dd;
        rr = r[1:0];
        cc = c[1:0];
        dd = d[7:0];
        return {op, 1'b0, rr, cc, dd};
    endfunction

    task automatic model_apply(input logic [2:0] op, input int r, input int c, input int d);
        case (op)
            LDA: ma[r][c] = d;
            LDB: mb[r][c] = d;
            CLR: foreach (mc[x, y]) mc[x][y] = 0;
            CMP: begin
                for (int x = 0; x < N; x++)
                    for (int y = 0; y < N; y++) begin
                        int s = 0;
                        for (int k = 0; k < N; k++) s += ma[x][k] * mb[k][y];
                        mc[x][y] = (mc[x][y] + s) % 65536;
                    end
            end
            default: ;
        endcase
    endtask

    task automatic send(input logic [2:0] op, input int r, input int c, input int d);
        int n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = mk(op, r, c, d);
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: instr_ready=%0b required 1", instr_ready);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        model_apply(op, r, c, d);
    endtask

    task automatic read_expect(input int r, input int c, input int exp, input string name);
        send(RD, r, c, 0);
        @(negedge clk);
        total++;
        if (result_valid !== 1'b1 || result !== ACC_W'(exp)) begin
            bad++;
            $display("FAIL %s: result=%0d valid=%0b required %0d valid=1", name, result, result_valid, exp);
        end
    endtask

    task automatic run_compute(output int cycles, output int done_at, output int done_cnt);
        send(CMP, 0, 0, 0);
        cycles = 0; done_at = -1; done_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (done) begin
                done_at = cycles;
                done_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instruction = '0;
        foreach (ma[x, y]) begin ma[x][y] = 0; mb[x][y] = 0; mc[x][y] = 0; end
        repeat (3) @(negedge clk);
        total++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            result !== '0 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%0b busy=%0b done=%0b result=%0d rv=%0b required 1 0 0 0 0",
                     instr_ready, busy, done, result, result_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity;
        int cyc, dat, dcnt;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                send(LDA, i, j, (i == j) ? 1 : 0);
                send(LDB, i, j, 4 * i + j + 1);
            end
        send(CLR, 0, 0, 0);
        run_compute(cyc, dat, dcnt);
        total++;
        if (cyc !== 3 * N - 2 || dat !== 3 * N - 2 || dcnt !== 1) begin
            bad++;
            $display("FAIL run_length: busy_cycles=%0d done_at=%0d dones=%0d required %0d %0d 1",
                     cyc, dat, dcnt, 3 * N - 2, 3 * N - 2);
        end
        read_expect(1, 2, 7, "identity_c12");
        run_compute(cyc, dat, dcnt);
        read_expect(1, 2, 14, "accumulate_c12");
        send(CLR, 0, 0, 0);
        read_expect(3, 3, 0, "clear_c33");
    endtask

    task automatic test_wrap;
        int cyc, dat, dcnt;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                send(LDA, i, j, 255);
                send(LDB, i, j, 255);
            end
        send(CLR, 0, 0, 0);
        run_compute(cyc, dat, dcnt);
        read_expect(0, 0, 63492, "wrap_c00");
    endtask

    task automatic test_hold_during_run;
        int n = 0;
        bit saw_done = 0;
        int cyc, dat, dcnt;
        send(CLR, 0, 0, 0);
        send(CMP, 0, 0, 0);
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = mk(LDA, 0, 0, 3);
        total++;
        if (instr_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_ready: instr_ready=%0b busy=%0b required 0 1", instr_ready, busy);
        end
        while (!instr_ready && n < 60) begin
            if (done) saw_done = 1;
            @(negedge clk);
            n++;
        end
        total++;
        if (!saw_done || !instr_ready) begin
            bad++;
            $display("FAIL hold_done_first: saw_done=%0b ready=%0b required 1 1", saw_done, instr_ready);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        model_apply(LDA, 0, 0, 3);
        read_expect(0, 0, mc[0][0], "hold_old_a_used");
        send(CLR, 0, 0, 0);
        run_compute(cyc, dat, dcnt);
        read_expect(0, 0, mc[0][0], "hold_load_applied");
    endtask

    task automatic test_back_to_back;
        int e00 = mc[0][0];
        int e33 = mc[3][3];
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = mk(RD, 0, 0, 0);
        @(posedge clk);
        #1 instruction = mk(RD, 3, 3, 0);
        @(negedge clk);
        total++;
        if (result_valid !== 1'b1 || result !== ACC_W'(e00)) begin
            bad++;
            $display("FAIL b2b_first: result=%0d valid=%0b required %0d 1", result, result_valid, e00);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b1 || result !== ACC_W'(e33)) begin
            bad++;
            $display("FAIL b2b_second: result=%0d valid=%0b required %0d 1", result, result_valid, e33);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || result !== ACC_W'(e33)) begin
            bad++;
            $display("FAIL b2b_hold: result=%0d valid=%0b required %0d 0", result, result_valid, e33);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        send(CMP, 0, 0, 0);
        repeat (6) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_busy: busy=%0b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%0b done=%0b ready=%0b rv=%0b required 0 0 1 0",
                     busy, done, instr_ready, result_valid);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL midrun_no_done: done_or_busy_cycles=%0d required 0", dones);
        end
        foreach (ma[x, y]) begin ma[x][y] = 0; mb[x][y] = 0; mc[x][y] = 0; end
        read_expect(0, 0, 0, "midrun_c00_cleared");
    endtask

    task automatic test_random;
        int cyc, dat, dcnt;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    send(LDA, i, j, int'($urandom_range(0, 255)));
                    send(LDB, i, j, int'($urandom_range(0, 255)));
                end
            if ($urandom_range(0, 1) == 1) send(CLR, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) send(NOP, 0, 0, 0);
            run_compute(cyc, dat, dcnt);
            total++;
            if (cyc !== 3 * N - 2 || dat !== 3 * N - 2 || dcnt !== 1) begin
                bad++;
                $display("FAIL rand_run_length: busy_cycles=%0d done_at=%0d dones=%0d required %0d %0d 1",
                         cyc, dat, dcnt, 3 * N - 2, 3 * N - 2);
            end
            for (int k = 0; k < 4; k++) begin
                int r = int'($urandom_range(0, N - 1));
                int c = int'($urandom_range(0, N - 1));
                read_expect(r, c, mc[r][c], "rand_read");
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_wrap();
        test_hold_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
